// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared RV32I definitions for the front end and the control unit:
//   - OPC_* major opcode constants (instr[6:0])
//   - NOP_INSTR    canonical no-op (addi x0,x0,0)
//   - fetch_state_t fetch FSM states {REQ, WAIT, HOLD, DRAIN}
//   - is_word_aligned() helper for target address checks
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        REQ   = 2'd0,   // present request to instruction memory
        WAIT  = 2'd1,   // request outstanding, waiting for response
        HOLD  = 2'd2,   // instruction presented to decode
        DRAIN = 2'd3    // redirected while outstanding; swallow stale response
    } fetch_state_t;

    // True when the two low address bits select a 32-bit word boundary.
    function automatic logic is_word_aligned(input logic [1:0] low_bits);
        return (low_bits == 2'b00);
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// ---------------------------------------------------------------------------
// pc_next_sel
// Combinational next-PC candidates for the fetch unit.
//   pc_i          current fetch PC
//   redirect_pc_i raw redirect target from execute
//   pc_inc_o      pc_i + 4 (wraps modulo 2^XLEN)
//   target_o      redirect target to load into the PC
//   target_bad_o  target is not word aligned (trap builds only)
// Build option MISALIGN_TRAP_EN: when defined, a misaligned target is flagged
// on target_bad_o and passed through unchanged; when undefined the two low
// bits are cleared and target_bad_o is tied low.
// ---------------------------------------------------------------------------
module pc_next_sel #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic [XLEN-1:0] pc_inc_o,
    output logic [XLEN-1:0] target_o,
    output logic            target_bad_o
);
    import riscv_pkg::*;

    localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

    assign pc_inc_o = pc_i + PC_STEP;

`ifdef MISALIGN_TRAP_EN
    assign target_o     = redirect_pc_i;
    assign target_bad_o = ~is_word_aligned(redirect_pc_i[1:0]);
`else
    logic unused_low_bits_s;

    // Low bits are discarded: targets are always forced onto a word boundary.
    assign unused_low_bits_s = ^redirect_pc_i[1:0];
    assign target_o          = {redirect_pc_i[XLEN-1:2], 2'b00};
    assign target_bad_o      = 1'b0;
`endif

endmodule

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Owns the PC, fetches 32-bit RV32I words over a req/valid memory handshake
// and presents them to decode over a valid/ready handshake. Redirects from
// execute (taken branch / jump) override sequential flow in every state.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   imem_req / imem_addr     fetch request, address stable while req is high
//   imem_rdata / imem_valid  fetched word and one-cycle response strobe
//   redirect_en/redirect_pc  redirect request and target
//   instr_valid/instr_ready  decode handshake
//   instr, opcode, pc_out    presented instruction, its opcode and address
//   pc_plus4                 pc_out + 4 (JAL link value)
//   fetch_fault              sticky misaligned-target flag
//
// Build option MISALIGN_TRAP_EN: a misaligned redirect leaves the PC alone,
// raises fetch_fault (sticky until reset) and freezes the FSM in REQ with
// imem_req low. Without it, targets are word-aligned and fetch_fault is 0.
//
// At most one memory request is outstanding. The memory must answer at the
// earliest one cycle after the cycle in which the FSM entered WAIT.
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0]     NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_valid,
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [6:0]      opcode,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus4,
    output logic            fetch_fault
);
    import riscv_pkg::*;

    localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_out_q, pc_out_d;
    logic [31:0]     instr_q, instr_d;
    logic            valid_q, valid_d;
    logic            fault_q, fault_d;

    logic [XLEN-1:0] pc_inc_s;
    logic [XLEN-1:0] target_s;
    logic            target_bad_s;
    logic            redir_ok_s;
    logic            redir_bad_s;

    pc_next_sel #(
        .XLEN (XLEN)
    ) u_pc_next_sel (
        .pc_i          (pc_q),
        .redirect_pc_i (redirect_pc),
        .pc_inc_o      (pc_inc_s),
        .target_o      (target_s),
        .target_bad_o  (target_bad_s)
    );

    assign redir_ok_s  = redirect_en & ~target_bad_s;
    assign redir_bad_s = redirect_en &  target_bad_s;

    // Fetch FSM state and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= REQ;
            pc_q     <= RESET_PC;
            pc_out_q <= RESET_PC;
            instr_q  <= NOP_INSTR;
            valid_q  <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pc_out_q <= pc_out_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            fault_q  <= fault_d;
        end
    end

    // Next-state and datapath selection; redirects outrank instr_ready.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pc_out_d = pc_out_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        fault_d  = fault_q;

        if (fault_q) begin
            // Trapped: stay parked in REQ (imem_req is masked) until reset.
            state_d = REQ;
        end else if (redir_bad_s) begin
            fault_d = 1'b1;
            state_d = REQ;
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end else begin
            case (state_q)
                REQ: begin
                    if (redir_ok_s) begin
                        pc_d    = target_s;
                        state_d = REQ;
                    end else begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (redir_ok_s) begin
                        pc_d = target_s;
                        // A response landing with the redirect is simply dropped.
                        if (imem_valid) begin
                            state_d = REQ;
                        end else begin
                            state_d = DRAIN;
                        end
                    end else if (imem_valid) begin
                        instr_d  = imem_rdata;
                        pc_out_d = pc_q;
                        valid_d  = 1'b1;
                        state_d  = HOLD;
                    end else begin
                        state_d = WAIT;
                    end
                end
                HOLD: begin
                    if (redir_ok_s) begin
                        pc_d    = target_s;
                        valid_d = 1'b0;
                        instr_d = NOP_INSTR;
                        state_d = REQ;
                    end else if (instr_ready) begin
                        pc_d    = pc_inc_s;
                        valid_d = 1'b0;
                        instr_d = NOP_INSTR;
                        state_d = REQ;
                    end else begin
                        state_d = HOLD;
                    end
                end
                DRAIN: begin
                    if (redir_ok_s) begin
                        pc_d = target_s;
                    end else begin
                        pc_d = pc_q;
                    end
                    // The stale word is never captured.
                    if (imem_valid) begin
                        state_d = REQ;
                    end else begin
                        state_d = DRAIN;
                    end
                end
                default: begin
                    state_d = REQ;
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                end
            endcase
        end
    end

    // Request is a decode of the state register, forced low while in reset.
    assign imem_req    = rst_n & ~fault_q & ((state_q == REQ) | (state_q == WAIT));
    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[6:0];
    assign pc_out      = pc_out_q;
    assign pc_plus4    = pc_out_q + PC_STEP;

`ifdef MISALIGN_TRAP_EN
    assign fetch_fault = fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

endmodule
